// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of a single UART
// transmitter. A grant is held from arbitration through the requester's
// req_last byte. An optional channel-ID header byte is sent before each packet.
// A stall watchdog drops the grant if the owner goes quiet mid-packet.

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_HEADER    = 1,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       abort
);

  localparam int GW = $clog2(NUM_REQ);

  // Idle count at which the current idle cycle is the one that expires the grant.
  localparam logic [31:0] WD_LAST = (TIMEOUT_CLKS > 0) ? 32'(TIMEOUT_CLKS - 1) : 32'd0;
  // Ceiling for the idle counter so it can never wrap.
  localparam logic [31:0] WD_MAX  = 32'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t state;
  state_t state_next;

  // Requester that most recently finished or lost a grant; the search for
  // the next winner starts just after it.
  logic [GW-1:0] last_ptr;

  logic [GW-1:0] arb_cand;
  logic [GW-1:0] arb_pick;
  logic          arb_found;
  logic          grant_load;
  logic          grant_release;

  logic [NUM_REQ-1:0] grant_oh;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [7:0]         header_byte;
  logic [7:0]         req_bytes [NUM_REQ];

  logic [31:0] wd_cnt;
  logic        wd_expire;
  logic        pkt_done;

  // Split the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[8*gi +: 8];
  end

  // Signals of the currently granted requester.
  assign grant_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign g_valid     = |(req_valid & grant_oh);
  assign g_last      = |(req_last & grant_oh);
  assign g_data      = req_bytes[grant_id];
  assign header_byte = {4'hA, 4'(grant_id)};

  assign busy = (state != IDLE);

  // The owner is silent for the TIMEOUT_CLKS-th consecutive cycle: give up now.
  assign wd_expire = (TIMEOUT_CLKS > 0) && (state == DATA) && !g_valid && (wd_cnt >= WD_LAST);

  // The final byte of the packet moves to the UART this cycle.
  assign pkt_done = (state == DATA) && g_valid && tx_ready && g_last;

  // Round-robin search: first requester with valid set, starting after last_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_cand = GW'((int'(last_ptr) + k) % NUM_REQ);
      if (!arb_found && req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_pick  = arb_cand;
      end
    end
  end

  // FSM next state and the combinational UART / requester handshake outputs.
  always_comb begin
    state_next    = state;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    req_ready     = '0;
    abort         = 1'b0;
    grant_load    = 1'b0;
    grant_release = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_load = 1'b1;
          state_next = (ID_HEADER != 0) ? HEADER : DATA;
        end
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = header_byte;
        if (tx_ready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx_valid  = g_valid;
        tx_data   = g_data;
        req_ready = tx_ready ? grant_oh : '0;
        if (pkt_done) begin
          grant_release = 1'b1;
          state_next    = IDLE;
        end else if (wd_expire) begin
          abort         = 1'b1;
          grant_release = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant holder and round-robin pointer; req 0 wins the first arbitration.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      grant_id <= '0;
      last_ptr <= GW'(NUM_REQ - 1);
    end else begin
      if (grant_load) begin
        grant_id <= arb_pick;
      end
      if (grant_release) begin
        last_ptr <= grant_id;
      end
    end
  end

  // Stall watchdog: counts consecutive DATA cycles where the owner offers no byte.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wd_cnt <= 32'd0;
    end else if ((state != DATA) || (state_next != DATA) || g_valid) begin
      wd_cnt <= 32'd0;
    end else if (wd_cnt < WD_MAX) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

endmodule
